// File: rtl/avalon_mem_pkg.sv
// rtl/avalon_mem_pkg.sv - shared types and constants for the Avalon-MM memory slave
package avalon_mem_pkg;

  // Transfer sequencing: accept in IDLE, stall in WAIT, hand back in RESP.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} avm_state_t;

  localparam int DEF_MEM_WORDS = 1024;
  localparam int IDX_W         = $clog2(DEF_MEM_WORDS);
  localparam int BYTE_W        = 8;
  localparam int BYTE_LANES    = 4;
  // Wide enough for WAIT_CYCLES (max 15) plus a random extra of up to 3.
  localparam int CNT_W         = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/avalon_mem_slave_stall_lfsr.sv
// rtl/avalon_mem_slave_stall_lfsr.sv - 16-bit Fibonacci LFSR for pseudo-random stall lengths
import avalon_mem_pkg::*;

module stall_lfsr (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb_w;

  // Taps 16,14,13,11 give a maximal-length sequence.
  assign fb_w   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb_w};
  assign lfsr_o = lfsr_q;

  // Advance once per enable; reseed on reset so stall patterns are repeatable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/avalon_mem_slave.sv
// rtl/avalon_mem_slave.sv - Avalon-MM word memory slave with waitrequest stalls (option: AVALON_MEM_RANDOM_STALL_EN)
import avalon_mem_pkg::*;

module avalon_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          MEM_WORDS   = DEF_MEM_WORDS,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_err
);

  localparam int AW = $clog2(MEM_WORDS);

  avm_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     idx_q;
  logic              oor_q;
  logic              op_write_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       addr_q;
  logic [31:0]       readdata_q;
  logic              err_q;

  logic [31:0]       mem_q [MEM_WORDS];

  logic [31:0]       word_w;
  logic              oor_w;
  logic              req_one_w;
  logic              accept_w;
  logic              changed_w;
  logic              mem_we_w;
  logic [CNT_W-1:0]  stall_load_w;

  // Offset subtract wraps, so addresses below the base land far out of range.
  assign word_w    = (address - BASE_ADDR) >> 2;
  assign oor_w     = (word_w >= 32'(MEM_WORDS));
  assign req_one_w = read ^ write;
  assign accept_w  = (state_q == IDLE) && req_one_w;

  // The master must hold everything steady while stalled; any wobble is flagged.
  assign changed_w = (address    != addr_q)      ||
                     (read       != !op_write_q) ||
                     (write      != op_write_q)  ||
                     (writedata  != wdata_q)     ||
                     (byteenable != be_q);

`ifdef AVALON_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_w;

  stall_lfsr u_stall_lfsr (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (accept_w),
    .lfsr_o  (lfsr_w)
  );

  assign stall_load_w = CNT_W'(WAIT_CYCLES) + CNT_W'(lfsr_w[1:0]);
`else
  assign stall_load_w = CNT_W'(WAIT_CYCLES);
`endif

  // A read+write collision in IDLE is answered immediately with no access.
  assign waitrequest  = (read | write) && (state_q != RESP) &&
                        !((state_q == IDLE) && read && write);
  assign readdata     = readdata_q;
  assign protocol_err = err_q;

  // Commit point of a write; reset in the same cycle abandons it.
  assign mem_we_w = (state_q == WAIT) && (cnt_q == '0) && op_write_q &&
                    !oor_q && !reset;

  // Byte-lane write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_w) begin
      for (int n = 0; n < BYTE_LANES; n++) begin
        if (be_q[n]) begin
          mem_q[idx_q][n*BYTE_W +: BYTE_W] <= wdata_q[n*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Transfer FSM: latch the request, count down the stall, access, then respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      op_write_q <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      readdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read && write) begin
            err_q <= 1'b1;
          end else if (accept_w) begin
            idx_q      <= word_w[AW-1:0];
            oor_q      <= oor_w;
            op_write_q <= write;
            be_q       <= byteenable;
            wdata_q    <= writedata;
            addr_q     <= address;
            cnt_q      <= stall_load_w;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (changed_w) begin
            err_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!op_write_q) begin
              readdata_q <= oor_q ? 32'h0 : mem_q[idx_q];
            end
            if (oor_q) begin
              err_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
